// File: rtl/xif_instr_tracker.sv
// Tracks offloaded instructions in issue order and returns their results in that same order.
// Latency: a result appears one cycle after the later of its commit and its done; retiring an entry takes one cycle.
// Backpressure: the result is held stable while result_ready is low; issue_ready drops when the tracker is full or issue_id is already live.
//
// Ports:
//   clk, rst                    : clock; asynchronous active-high reset
//   issue_*                     : accepts a new offload (id, writeback flag, destination rd)
//   commit_*                    : commits or kills a live entry by id (may target the entry issued the same cycle)
//   done_*                      : execution result (data, exception) for a live, non-killed entry
//   result_*                    : in-order result of the head entry; all fields read 0 while result_valid is low
//   occupancy, proto_err        : live entry count; sticky flag for bad commits
module xif_instr_tracker #(
    parameter int X_ID_WIDTH  = 4,
    parameter int DEPTH       = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [X_ID_WIDTH-1:0]      issue_id,
    input  logic                       issue_writeback,
    input  logic [4:0]                 issue_rd,
    input  logic                       commit_valid,
    input  logic [X_ID_WIDTH-1:0]      commit_id,
    input  logic                       commit_kill,
    input  logic                       done_valid,
    input  logic [X_ID_WIDTH-1:0]      done_id,
    input  logic [X_RFW_WIDTH-1:0]     done_data,
    input  logic                       done_exc,
    input  logic [5:0]                 done_exccode,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [X_ID_WIDTH-1:0]      result_id,
    output logic [X_RFW_WIDTH-1:0]     result_data,
    output logic [4:0]                 result_rd,
    output logic                       result_we,
    output logic                       result_exc,
    output logic [5:0]                 result_exccode,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       proto_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]       live_q, live_d, wb_q, wb_d, cmt_q, cmt_d;
    logic [DEPTH-1:0]       kill_q, kill_d, done_q, done_d, exc_q, exc_d;
    logic [X_ID_WIDTH-1:0]  id_q [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_d [DEPTH];
    logic [4:0]             rd_q [DEPTH];
    logic [4:0]             rd_d [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_d [DEPTH];
    logic [5:0]             xc_q [DEPTH];
    logic [5:0]             xc_d [DEPTH];
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [OW-1:0]          occ_q, occ_d;
    logic                   perr_q, perr_d;

    logic issue_dup, issue_acc, retire, res_vld;
    logic commit_hit, commit_dup, commit_new;

    always_comb begin
        live_d = live_q;  wb_d = wb_q;  cmt_d = cmt_q;
        kill_d = kill_q;  done_d = done_q;  exc_d = exc_q;
        id_d = id_q;  rd_d = rd_q;  data_d = data_q;  xc_d = xc_q;
        head_d = head_q;  tail_d = tail_q;  occ_d = occ_q;  perr_d = perr_q;
        issue_dup  = 1'b0;
        commit_hit = 1'b0;
        commit_dup = 1'b0;
        commit_new = 1'b0;

        // Live ids are unique, so at most one entry matches any id lookup.
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && id_q[i] == issue_id) begin
                issue_dup = 1'b1;
            end
        end
        issue_ready = !rst && (occ_q < OW'(DEPTH)) && !issue_dup;
        issue_acc   = issue_valid && issue_ready;

        res_vld = live_q[head_q] && cmt_q[head_q] && !kill_q[head_q] && done_q[head_q];
        // A killed head drains on its own; a good head waits for the consumer.
        retire  = live_q[head_q] && cmt_q[head_q] && (kill_q[head_q] || (done_q[head_q] && result_ready));

        if (commit_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && id_q[i] == commit_id) begin
                    commit_hit = 1'b1;
                    if (cmt_q[i]) begin
                        commit_dup = 1'b1;
                    end else begin
                        cmt_d[i]  = 1'b1;
                        kill_d[i] = commit_kill;
                    end
                end
            end
            // Commit may land on the entry being issued in this very cycle.
            commit_new = !commit_hit && issue_acc && (issue_id == commit_id);
            if ((!commit_hit && !commit_new) || commit_dup) begin
                perr_d = 1'b1;
            end
        end

        if (done_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (live_q[i] && !kill_q[i] && id_q[i] == done_id) begin
                    done_d[i] = 1'b1;
                    data_d[i] = done_data;
                    exc_d[i]  = done_exc;
                    xc_d[i]   = done_exccode;
                end
            end
        end

        if (retire) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PW'(1);
        end

        // Tail never aliases a live head here: issue is refused when full.
        if (issue_acc) begin
            live_d[tail_q] = 1'b1;
            id_d[tail_q]   = issue_id;
            wb_d[tail_q]   = issue_writeback;
            rd_d[tail_q]   = issue_rd;
            cmt_d[tail_q]  = commit_new;
            kill_d[tail_q] = commit_new && commit_kill;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + PW'(1);
        end

        occ_d = occ_q + OW'(issue_acc) - OW'(retire);

        result_valid   = res_vld;
        result_id      = res_vld ? id_q[head_q]   : '0;
        result_data    = res_vld ? data_q[head_q] : '0;
        result_rd      = res_vld ? rd_q[head_q]   : '0;
        result_we      = res_vld && wb_q[head_q] && !exc_q[head_q];
        result_exc     = res_vld && exc_q[head_q];
        result_exccode = res_vld ? xc_q[head_q]   : '0;
        occupancy      = occ_q;
        proto_err      = perr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;  wb_q <= '0;  cmt_q <= '0;
            kill_q <= '0;  done_q <= '0;  exc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
                xc_q[i]   <= '0;
            end
            head_q <= '0;  tail_q <= '0;  occ_q <= '0;  perr_q <= 1'b0;
        end else begin
            live_q <= live_d;  wb_q <= wb_d;  cmt_q <= cmt_d;
            kill_q <= kill_d;  done_q <= done_d;  exc_q <= exc_d;
            id_q <= id_d;  rd_q <= rd_d;  data_q <= data_d;  xc_q <= xc_d;
            head_q <= head_d;  tail_q <= tail_d;  occ_q <= occ_d;  perr_q <= perr_d;
        end
    end

endmodule
